// File: rtl/car_cruise_ctrl.sv
//------------------------------------------------------------------------------
// car_cruise_ctrl
// Adaptive cruise / stop-and-go controller: a five-state Moore FSM with speed
// hysteresis, a door-unlock dwell timer and a saturating emergency-brake count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module car_cruise_ctrl #(
  parameter int SPD_W      = 8,
  parameter int DIST_W     = 8,
  parameter int MIN_DIST   = 40,
  parameter int BRAKE_DIST = 15,
  parameter int HYST       = 5,
  parameter int DOOR_DLY   = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [SPD_W-1:0]  speed_limit,
  input  logic [SPD_W-1:0]  car_speed,
  input  logic [DIST_W-1:0] leading_distance,
  output logic              unlock_door,
  output logic              accelerate_car,
  output logic              brake_car,
  output logic              emergency,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  ebrake_count
);

  localparam int SC_W = (DOOR_DLY < 1) ? 1 : $clog2(DOOR_DLY + 1);

  localparam logic [DIST_W-1:0] c_MIN_DIST   = DIST_W'(MIN_DIST);
  localparam logic [DIST_W-1:0] c_BRAKE_DIST = DIST_W'(BRAKE_DIST);
  localparam logic [SPD_W:0]    c_HYST       = (SPD_W + 1)'(HYST);
  localparam logic [SC_W-1:0]   c_DOOR_DLY   = SC_W'(DOOR_DLY);

  typedef enum logic [2:0] {
    ST_STOP   = 3'b000,
    ST_ACCEL  = 3'b001,
    ST_CRUISE = 3'b010,
    ST_DECEL  = 3'b011,
    ST_EBRAKE = 3'b100
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SC_W-1:0] r_stop_cnt;
  logic [SC_W-1:0] w_stop_cnt_nxt;

  logic w_near, w_danger, w_over, w_low, w_stopped;

  // The hysteresis sum is one bit wider so a limit near full scale cannot wrap.
  assign w_near    = leading_distance < c_MIN_DIST;
  assign w_stopped = car_speed == '0;
  assign w_danger  = (leading_distance < c_BRAKE_DIST) && !w_stopped;
  assign w_over    = car_speed > speed_limit;
  assign w_low     = ({1'b0, car_speed} + c_HYST) < {1'b0, speed_limit};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_STOP: begin
        if (enable && !w_near) w_next = ST_ACCEL;
      end
      ST_ACCEL: begin
        if (w_danger)                        w_next = ST_EBRAKE;
        else if (!enable || w_near || w_over) w_next = ST_DECEL;
        else if (!w_low)                     w_next = ST_CRUISE;
      end
      ST_CRUISE: begin
        if (w_danger)                        w_next = ST_EBRAKE;
        else if (!enable || w_near || w_over) w_next = ST_DECEL;
        else if (w_low)                      w_next = ST_ACCEL;
      end
      ST_DECEL: begin
        if (w_danger)                           w_next = ST_EBRAKE;
        else if (w_stopped)                     w_next = ST_STOP;
        else if (enable && !w_near && w_low)    w_next = ST_ACCEL;
        else if (enable && !w_near && !w_over)  w_next = ST_CRUISE;
      end
      ST_EBRAKE: begin
        if (w_stopped) w_next = ST_STOP;
      end
      default: w_next = ST_STOP;
    endcase
  end

  // Dwell timer restarts on entry to STOP and holds once the delay is reached.
  always_comb begin
    w_stop_cnt_nxt = '0;
    if (w_next == ST_STOP && r_state == ST_STOP) begin
      w_stop_cnt_nxt = (r_stop_cnt < c_DOOR_DLY) ? r_stop_cnt + 1'b1 : r_stop_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_STOP;
      r_stop_cnt     <= '0;
      ebrake_count   <= '0;
      unlock_door    <= 1'b0;
      accelerate_car <= 1'b0;
      brake_car      <= 1'b1;
      emergency      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_stop_cnt     <= w_stop_cnt_nxt;
      if (w_next == ST_EBRAKE && r_state != ST_EBRAKE && ebrake_count != '1) begin
        ebrake_count <= ebrake_count + 1'b1;
      end
      // Outputs are decoded from the next state so they track the state register.
      unlock_door    <= (w_next == ST_STOP) && (w_stop_cnt_nxt == c_DOOR_DLY);
      accelerate_car <= (w_next == ST_ACCEL);
      brake_car      <= (w_next == ST_STOP) || (w_next == ST_DECEL) || (w_next == ST_EBRAKE);
      emergency      <= (w_next == ST_EBRAKE);
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_car_cruise_ctrl.sv
//------------------------------------------------------------------------------
// tb_car_cruise_ctrl
// Directed self-checking bench for car_cruise_ctrl with default parameters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_car_cruise_ctrl;

  localparam logic [2:0] S_STOP   = 3'b000;
  localparam logic [2:0] S_ACCEL  = 3'b001;
  localparam logic [2:0] S_CRUISE = 3'b010;
  localparam logic [2:0] S_DECEL  = 3'b011;
  localparam logic [2:0] S_EBRAKE = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] speed_limit;
  logic [7:0] car_speed;
  logic [7:0] leading_distance;
  logic       unlock_door;
  logic       accelerate_car;
  logic       brake_car;
  logic       emergency;
  logic [2:0] state;
  logic [7:0] ebrake_count;

  int checks = 0;
  int errors = 0;

  car_cruise_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .speed_limit      (speed_limit),
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .unlock_door      (unlock_door),
    .accelerate_car   (accelerate_car),
    .brake_car        (brake_car),
    .emergency        (emergency),
    .state            (state),
    .ebrake_count     (ebrake_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    speed_limit = 8'd120;
    car_speed = 8'd0;
    leading_distance = 8'd200;
    #1;
    check("rst_state", state, S_STOP);
    check("rst_brake", brake_car, 1'b1);
    check("rst_accel", accelerate_car, 1'b0);
    check("rst_unlock", unlock_door, 1'b0);
    check("rst_emerg", emergency, 1'b0);
    check("rst_count", ebrake_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Door dwell after reset: three edges locked, fourth unlocks.
    for (int i = 1; i <= 3; i++) begin
      step();
      check("dwell_locked", unlock_door, 1'b0);
    end
    step();
    check("dwell_unlock", unlock_door, 1'b1);
    step();
    check("dwell_hold", unlock_door, 1'b1);

    enable = 1'b1;
    step();
    check("go_state", state, S_ACCEL);
    check("go_accel", accelerate_car, 1'b1);
    check("go_unlock", unlock_door, 1'b0);
    check("go_brake", brake_car, 1'b0);

    // Hysteresis around speed_limit = 120.
    car_speed = 8'd110; step(); check("acc_110", state, S_ACCEL);
    car_speed = 8'd115; step(); check("acc_115", state, S_CRUISE);
    car_speed = 8'd121; step(); check("cru_121", state, S_DECEL);
    check("dec_brake", brake_car, 1'b1);
    car_speed = 8'd114; step(); check("dec_114", state, S_ACCEL);
    car_speed = 8'd118; step(); check("acc_118", state, S_CRUISE);

    leading_distance = 8'd30; step();
    check("near_state", state, S_DECEL);
    check("near_brake", brake_car, 1'b1);
    leading_distance = 8'd50; step(); check("clear_state", state, S_CRUISE);
    enable = 1'b0; step(); check("dis_state", state, S_DECEL);
    car_speed = 8'd0; step();
    check("stop_state", state, S_STOP);
    check("stop_unlock", unlock_door, 1'b0);

    // Emergency braking latches until standstill.
    enable = 1'b1; car_speed = 8'd80; step(); check("eb_pre", state, S_ACCEL);
    leading_distance = 8'd10; step();
    check("eb_state", state, S_EBRAKE);
    check("eb_emerg", emergency, 1'b1);
    check("eb_count1", ebrake_count, 8'd1);
    check("eb_brake", brake_car, 1'b1);
    enable = 1'b0; leading_distance = 8'd200; car_speed = 8'd40; step();
    check("eb_latch", state, S_EBRAKE);
    check("eb_count_hold", ebrake_count, 8'd1);
    car_speed = 8'd0; step();
    check("eb_stop", state, S_STOP);
    check("eb_stop_emerg", emergency, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("eb_dwell_locked", unlock_door, 1'b0);
    end
    step();
    check("eb_dwell_unlock", unlock_door, 1'b1);

    // Limit at full scale: speed + HYST must not wrap back to "low".
    enable = 1'b1; speed_limit = 8'd255; car_speed = 8'd253; step();
    check("top_accel", state, S_ACCEL);
    check("top_unlock", unlock_door, 1'b0);
    step(); check("top_253", state, S_CRUISE);
    car_speed = 8'd255; step(); check("top_255", state, S_CRUISE);

    // Danger and over together: EBRAKE wins over DECEL.
    speed_limit = 8'd50; car_speed = 8'd80; leading_distance = 8'd10; step();
    check("prio_state", state, S_EBRAKE);
    check("prio_count2", ebrake_count, 8'd2);

    // Drive 257 more entries: 259 in total, counter saturates at 255.
    for (int n = 0; n < 257; n++) begin
      car_speed = 8'd0; step();
      leading_distance = 8'd200; step();
      car_speed = 8'd80; leading_distance = 8'd10; step();
    end
    check("sat_state", state, S_EBRAKE);
    check("sat_count", ebrake_count, 8'd255);

    car_speed = 8'd0; step();
    leading_distance = 8'd200; step();
    check("sat_accel", state, S_ACCEL);
    check("sat_count_hold", ebrake_count, 8'd255);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_state", state, S_STOP);
    check("arst_count", ebrake_count, 8'd0);
    check("arst_accel", accelerate_car, 1'b0);
    check("arst_brake", brake_car, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("resume_state", state, S_ACCEL);
    check("resume_accel", accelerate_car, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
